// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: load/store bridge between the core data-memory port and a req/ack data bus.
//
// The bridge accepts one core access at a time and stalls the core while the bus transaction
// is outstanding. It builds byte enables and lane-replicated store data, aligns and
// sign/zero-extends load data, and reports bus errors and timeouts.
//
// Parameters:
//   AW      - byte address width (data width is fixed at 32)
//   TIMEOUT - max BUSY cycles without ack/err before an error response; 0 disables the timeout
//
// Ports:
//   clk, reset         - clock (rising edge), synchronous active-low reset
//   cpu_req..cpu_wdata - core access request, held stable by the core while cpu_stall=1
//   cpu_stall          - hold the core this cycle
//   cpu_done, cpu_err  - one-cycle completion pulse and its error flag
//   cpu_rdata          - registered, aligned and extended load data
//   bus_req..bus_wdata - bus request and its registered address/control/data
//   bus_ack, bus_err   - bus completion / failure, bus_rdata valid with bus_ack
//
// Configuration:
//   MISALIGN_CHECK_EN - when defined, misaligned half/word accesses complete with cpu_err set
//                       without issuing a bus request.

module lsu_bus_bridge #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_size,
    input  logic          cpu_unsigned,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_done,
    output logic          cpu_err,
    output logic [31:0]   cpu_rdata,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic          bus_ack,
    input  logic          bus_err,
    input  logic [31:0]   bus_rdata
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    size_q;
    logic [1:0]    off_q;
    logic          unsigned_q;

    // Request decode from the live core inputs; registered onto the bus on acceptance.
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    always_comb begin
        req_be    = 4'hF;
        req_wdata = cpu_wdata;
        case (cpu_size)
            2'b00: begin
                req_be    = 4'b0001 << cpu_addr[1:0];
                req_wdata = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                req_be    = 4'b0011 << {cpu_addr[1], 1'b0};
                req_wdata = {2{cpu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = ((cpu_size == 2'b01) && cpu_addr[0]) ||
                        (cpu_size[1] && (cpu_addr[1:0] != 2'b00));
`endif

    // Load alignment: shift the addressed lane down to bit 0, then extend.
    logic [1:0]  shift_lane;
    logic [31:0] shifted;
    logic [31:0] load_data;

    always_comb begin
        case (size_q)
            2'b00:   shift_lane = off_q;
            2'b01:   shift_lane = {off_q[1], 1'b0};
            default: shift_lane = 2'b00;
        endcase
        shifted = bus_rdata >> {shift_lane, 3'b000};
        case (size_q)
            2'b00:   load_data = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    logic timeout_hit;
    assign timeout_hit = (TIMEOUT != 0) && (count == CW'(TIMEOUT - 1));

    // In IDLE the stall follows the request so the core holds while it is being accepted.
    assign cpu_stall = reset && ((state == StBusy) || ((state == StIdle) && cpu_req));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= StIdle;
            count      <= '0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            unsigned_q <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= 32'h0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'h0;
            bus_wdata  <= 32'h0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            case (state)
                StIdle: begin
                    if (cpu_req) begin
                        size_q     <= cpu_size;
                        off_q      <= cpu_addr[1:0];
                        unsigned_q <= cpu_unsigned;
                        bus_we     <= cpu_we;
                        bus_addr   <= {cpu_addr[AW-1:2], 2'b00};
                        bus_be     <= req_be;
                        bus_wdata  <= req_wdata;
                        count      <= '0;
`ifdef MISALIGN_CHECK_EN
                        if (misaligned) begin
                            state    <= StResp;
                            cpu_done <= 1'b1;
                            cpu_err  <= 1'b1;
                        end else begin
                            state   <= StBusy;
                            bus_req <= 1'b1;
                        end
`else
                        state   <= StBusy;
                        bus_req <= 1'b1;
`endif
                    end
                end
                StBusy: begin
                    count <= count + 1'b1;
                    // Priority: bus_err over bus_ack over timeout.
                    if (bus_err) begin
                        state    <= StResp;
                        bus_req  <= 1'b0;
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b1;
                    end else if (bus_ack) begin
                        state    <= StResp;
                        bus_req  <= 1'b0;
                        cpu_done <= 1'b1;
                        if (!bus_we) begin
                            cpu_rdata <= load_data;
                        end
                    end else if (timeout_hit) begin
                        state    <= StResp;
                        bus_req  <= 1'b0;
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b1;
                    end
                end
                StResp: begin
                    // The core still presents the completed access here; do not re-accept it.
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Scoreboard bench for lsu_bus_bridge: a driver issues core accesses and pushes the expected
// bus transaction and core response; a bus responder and a core-side monitor check them.

module tb_lsu_bus_bridge;

    localparam int unsigned AW      = 32;
    localparam int unsigned TIMEOUT = 16;

    localparam int KAck  = 0;
    localparam int KErr  = 1;
    localparam int KBoth = 2;
    localparam int KTo   = 3;
    localparam int KRst  = 4;

    logic          clk;
    logic          reset;
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_size;
    logic          cpu_unsigned;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic          cpu_done;
    logic          cpu_err;
    logic [31:0]   cpu_rdata;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic          bus_ack;
    logic          bus_err;
    logic [31:0]   bus_rdata;

    lsu_bus_bridge #(
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_size     (cpu_size),
        .cpu_unsigned (cpu_unsigned),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_stall    (cpu_stall),
        .cpu_done     (cpu_done),
        .cpu_err      (cpu_err),
        .cpu_rdata    (cpu_rdata),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          kind;
        int          delay;
        logic [31:0] rdata;
    } bus_txn_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    bus_txn_t    bus_q[$];
    resp_t       exp_q[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          n_done     = 0;
    int          n_expected = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pick the addressed byte/halfword arithmetically and extend it.
    function automatic logic [31:0] load_model(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] word);
        logic [31:0] v;
        int unsigned lane;
        if (size == 2'b00) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            lane = (off >= 2'd2) ? 2 : 0;
            v = (word >> (8 * lane)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [3:0] be_model(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'b00) return 4'(1 << off);
        if (size == 2'b01) return 4'(3 << ((off >= 2'd2) ? 2 : 0));
        return 4'hF;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'b00) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int kind,
                         input int delay, input logic [31:0] rdata);
        bus_txn_t t;
        resp_t    r;
        int       lat;
        int       cyc;
        logic     done_seen;
        t.addr  = addr & 32'hFFFF_FFFC;
        t.be    = be_model(size, addr[1:0]);
        t.we    = we;
        t.wdata = wdata_model(size, wdata);
        t.kind  = kind;
        t.delay = delay;
        t.rdata = rdata;
        bus_q.push_back(t);
        r.err = (kind != KAck);
        if (kind == KAck && !we) model_rdata = load_model(size, uns, addr[1:0], rdata);
        r.rdata = model_rdata;
        exp_q.push_back(r);
        n_expected++;
        lat = (kind == KTo) ? int'(TIMEOUT) + 1 : delay + 2;

        @(negedge clk);
        cpu_req      = 1'b1;
        cpu_we       = we;
        cpu_size     = size;
        cpu_unsigned = uns;
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        #1 check("stall_on_req", 32'(cpu_stall), 32'd1);
        cyc       = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cpu_done) done_seen = 1'b1;
            else check("stall_busy", 32'(cpu_stall), 32'd1);
        end
        cpu_req  = 1'b0;
        cpu_addr = $urandom;
        check("latency", 32'(cyc), 32'(lat));
    endtask

    // Core-side monitor.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (cpu_done === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: cpu_done=1, expected 0 at %0t", $time);
                end else begin
                    r = exp_q.pop_front();
                    check("cpu_err", 32'(cpu_err), 32'(r.err));
                    check("cpu_rdata", cpu_rdata, r.rdata);
                    check("stall_in_resp", 32'(cpu_stall), 32'd0);
                end
            end
        end
    end

    // Bus responder: checks the request fields and answers per the queued plan.
    initial begin
        bus_txn_t t;
        int       n;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                if (bus_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_bus_req: bus_req=1, expected 0 at %0t", $time);
                    n = 0;
                    while (bus_req === 1'b1 && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    t = bus_q.pop_front();
                    check("bus_addr", bus_addr, t.addr);
                    check("bus_be", 32'(bus_be), 32'(t.be));
                    check("bus_we", 32'(bus_we), 32'(t.we));
                    if (t.we) check("bus_wdata", bus_wdata, t.wdata);
                    if (t.kind <= KBoth) begin
                        repeat (t.delay) begin
                            @(negedge clk);
                            check("bus_req_held", 32'(bus_req), 32'd1);
                        end
                        bus_ack   = (t.kind != KErr);
                        bus_err   = (t.kind != KAck);
                        bus_rdata = t.rdata;
                        @(negedge clk);
                        bus_ack   = 1'b0;
                        bus_err   = 1'b0;
                        bus_rdata = $urandom;
                        check("bus_req_drop", 32'(bus_req), 32'd0);
                    end else begin
                        n = 0;
                        while (bus_req === 1'b1 && n < 100) begin
                            n++;
                            @(negedge clk);
                        end
                        if (t.kind == KTo) begin
                            check("bus_req_cycles", 32'(n), 32'(TIMEOUT));
                        end else begin
                            // Late ack after the transaction was killed by reset.
                            bus_ack   = 1'b1;
                            bus_rdata = 32'hCAFE_F00D;
                            repeat (2) @(negedge clk);
                            bus_ack   = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_txn_t    t;
        int          r;
        logic [1:0]  sz;
        reset        = 1'b0;
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_size     = 2'b00;
        cpu_unsigned = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_done", 32'(cpu_done), 32'd0);
        check("rst_err", 32'(cpu_err), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        reset = 1'b1;

        // Directed cases.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, KAck, 1, 32'hDEAD_BEEF);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, KAck, 0, 32'h80FF_FF00);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, KAck, 2, 32'h80FF_FF00);
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_ABCD, KAck, 0, 32'h5555_5555);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, KTo, 0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, KBoth, 2, 32'h1111_2222);
        issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, KAck, int'(TIMEOUT) - 1, 32'h9ABC_1234);
        issue(1'b1, 2'b11, 1'b0, 32'h48, 32'hA5A5_0F0F, KErr, 3, 32'h0);

        // Randomized accesses.
        for (int i = 0; i < 150; i++) begin
            r  = int'($urandom_range(0, 99));
            sz = 2'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  (r < 75) ? KAck : (r < 85) ? KErr : (r < 95) ? KBoth : KTo,
                  int'($urandom_range(0, 4)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a transaction, followed by a late ack.
        t.addr  = 32'h80;
        t.be    = 4'hF;
        t.we    = 1'b0;
        t.wdata = 32'h0;
        t.kind  = KRst;
        t.delay = 0;
        t.rdata = 32'h0;
        bus_q.push_back(t);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_size = 2'b10;
        cpu_addr = 32'h80;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check("rst_mid_bus_req", 32'(bus_req), 32'd0);
        check("rst_mid_done", 32'(cpu_done), 32'd0);
        check("rst_mid_rdata", cpu_rdata, 32'd0);
        check("rst_mid_stall", 32'(cpu_stall), 32'd0);
        reset       = 1'b1;
        model_rdata = 32'h0;
        repeat (8) @(negedge clk);
        check("late_ack_no_done", 32'(n_done), 32'(n_expected));
        check("rdata_after_late_ack", cpu_rdata, model_rdata);

        repeat (5) @(negedge clk);
        check("queues_empty", 32'(bus_q.size() + exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_expected));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
